// File: rtl/gfx256_target_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gfx256_target_reader_if                                    |
// | Description : Wishbone classic read bus between the target reader        |
// |               (master) and the memory-side arbiter (slave).              |
// |   cyc, stb   master -> slave   cycle / strobe                            |
// |   we         master -> slave   write enable (reader drives 0)            |
// |   adr        master -> slave   32-bit line-aligned byte address          |
// |   sel        master -> slave   MDW/8 byte selects                        |
// |   dat_r      slave  -> master  MDW-bit read data                         |
// |   ack, err   slave  -> master  cycle termination                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface gfx256_target_reader_if #(
   parameter int MDW = 256
);
   logic             cyc;
   logic             stb;
   logic             we;
   logic [31:0]      adr;
   logic [MDW/8-1:0] sel;
   logic [MDW-1:0]   dat_r;
   logic             ack;
   logic             err;

   modport master (
      output cyc, stb, we, adr, sel,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, sel,
      output dat_r, ack, err
   );
endinterface
`default_nettype wire

// File: rtl/gfx256_target_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gfx256_target_reader                                       |
// | Description : Serves single 32-bit target reads for the blender. Misses  |
// |               fetch a whole MDW-bit line over Wishbone; a one-line cache |
// |               answers same-line reads in one clock without a bus cycle.  |
// | Ports       : clk_i, rst_ni            clock, async active-low reset     |
// |               target_request_i/addr_i  read request and byte address     |
// |               target_ack_o/data_o      one-cycle ack with read word      |
// |               wbm_busy_o               high whenever not IDLE            |
// |               invalidate_i             drop the cached line              |
// |               err_o / err_clr_i        sticky bus-error/timeout flag     |
// |               wb                       Wishbone master (read only)       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gfx256_target_reader #(
   parameter int MDW     = 256,
   parameter int TIMEOUT = 1023
) (
   input  wire logic                  clk_i,
   input  wire logic                  rst_ni,
   input  wire logic                  target_request_i,
   input  wire logic [31:0]           target_addr_i,
   output logic                       target_ack_o,
   output logic [31:0]                target_data_o,
   output logic                       wbm_busy_o,
   input  wire logic                  invalidate_i,
   output logic                       err_o,
   input  wire logic                  err_clr_i,
   gfx256_target_reader_if.master     wb
);
   localparam int OB = $clog2(MDW / 8);  // byte-offset bits within a line
   localparam int TW = 32 - OB;          // tag width
   localparam int IW = OB - 2;           // word-index width
   localparam logic [9:0] C_TIMEOUT = 10'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q,    state_d;
   logic [MDW-1:0]  line_q,     line_d;
   logic [TW-1:0]   tag_q,      tag_d;
   logic            valid_q,    valid_d;
   logic [TW-1:0]   req_tag_q,  req_tag_d;
   logic [IW-1:0]   req_idx_q,  req_idx_d;
   logic [31:0]     data_q,     data_d;
   logic            ack_q,      ack_d;
   logic            err_q,      err_d;
   logic            abort_q,    abort_d;
   logic [9:0]      cnt_q,      cnt_d;

   logic            w_accept;
   logic            w_hit;
   logic            w_err_set;

   function automatic logic [31:0] f_word(input logic [MDW-1:0] line,
                                          input logic [IW-1:0]  idx);
      return line[idx*32 +: 32];
   endfunction

   // While ack_q is high the requester is still holding the request it is
   // about to drop, so it must not be taken as a new one.
   assign w_accept = target_request_i & ~ack_q;
   assign w_hit    = valid_q & (tag_q == target_addr_i[31:OB]) & ~invalidate_i;

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      tag_d     = tag_q;
      valid_d   = valid_q;
      req_tag_d = req_tag_q;
      req_idx_d = req_idx_q;
      data_d    = data_q;
      ack_d     = 1'b0;
      err_d     = err_q;
      abort_d   = abort_q;
      cnt_d     = cnt_q;
      w_err_set = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               if (w_hit) begin
                  data_d = f_word(line_q, target_addr_i[OB-1:2]);
                  ack_d  = 1'b1;
               end else begin
                  state_d   = S_BUS;
                  req_tag_d = target_addr_i[31:OB];
                  req_idx_d = target_addr_i[OB-1:2];
                  cnt_d     = 10'd0;
                  abort_d   = 1'b0;
               end
            end
         end
         S_BUS: begin
            // err has priority over ack; a timeout is handled like an error.
            if (wb.err || (cnt_q == C_TIMEOUT)) begin
               state_d   = S_RESP;
               abort_d   = 1'b1;
               data_d    = 32'd0;
               valid_d   = 1'b0;
               w_err_set = 1'b1;
            end else if (wb.ack) begin
               state_d = S_RESP;
               line_d  = wb.dat_r;
               tag_d   = req_tag_q;
               valid_d = ~invalidate_i;
            end else if (cnt_q != C_TIMEOUT) begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         S_RESP: begin
            ack_d   = 1'b1;
            state_d = S_IDLE;
            if (!abort_q) begin
               data_d = f_word(line_q, req_idx_q);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (invalidate_i) begin
         valid_d = 1'b0;
      end
      if (err_clr_i) begin
         err_d = 1'b0;
      end
      if (w_err_set) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         line_q    <= '0;
         tag_q     <= '0;
         valid_q   <= 1'b0;
         req_tag_q <= '0;
         req_idx_q <= '0;
         data_q    <= 32'd0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         abort_q   <= 1'b0;
         cnt_q     <= 10'd0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         tag_q     <= tag_d;
         valid_q   <= valid_d;
         req_tag_q <= req_tag_d;
         req_idx_q <= req_idx_d;
         data_q    <= data_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         abort_q   <= abort_d;
         cnt_q     <= cnt_d;
      end
   end

   assign target_ack_o  = ack_q;
   assign target_data_o = data_q;
   assign wbm_busy_o    = (state_q != S_IDLE);
   assign err_o         = err_q;

   assign wb.cyc = (state_q == S_BUS);
   assign wb.stb = (state_q == S_BUS);
   assign wb.we  = 1'b0;
   assign wb.adr = {req_tag_q, {OB{1'b0}}};
   assign wb.sel = (state_q == S_BUS) ? {(MDW/8){1'b1}} : {(MDW/8){1'b0}};
endmodule
`default_nettype wire

// File: tb/tb_gfx256_target_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gfx256_target_reader                                    |
// | Description : Directed self-checking bench for gfx256_target_reader with |
// |               a data scoreboard and a scripted Wishbone slave.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gfx256_target_reader;
   localparam int MDW     = 256;
   localparam int TIMEOUT = 1023;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        target_request_i = 1'b0;
   logic [31:0] target_addr_i = 32'd0;
   logic        target_ack_o;
   logic [31:0] target_data_o;
   logic        wbm_busy_o;
   logic        invalidate_i = 1'b0;
   logic        err_o;
   logic        err_clr_i = 1'b0;

   gfx256_target_reader_if #(.MDW(MDW)) wb ();

   gfx256_target_reader #(.MDW(MDW), .TIMEOUT(TIMEOUT)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .target_request_i (target_request_i),
      .target_addr_i    (target_addr_i),
      .target_ack_o     (target_ack_o),
      .target_data_o    (target_data_o),
      .wbm_busy_o       (wbm_busy_o),
      .invalidate_i     (invalidate_i),
      .err_o            (err_o),
      .err_clr_i        (err_clr_i),
      .wb               (wb.master)
   );

   always #5 clk_i = ~clk_i;

   int              n_vec = 0;
   int              n_err = 0;
   logic [31:0]     sb[$];
   logic [MDW-1:0]  cur_line = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [MDW-1:0] mk_line(input logic [31:0] seed);
      logic [MDW-1:0] l;
      for (int i = 0; i < MDW/32; i++) l[i*32 +: 32] = seed + 32'(i);
      return l;
   endfunction

   // mode: 0 = ack on cyc cycle dly, 1 = err on cyc cycle dly, 2 = never respond
   task automatic do_req(input logic [31:0] addr, input logic [31:0] exp,
                         input int mode, input int dly, input logic inv,
                         output logic saw_cyc, output int lat,
                         output logic [31:0] adr_seen, output int cyc_cnt);
      logic got;
      logic [31:0] d;
      @(negedge clk_i);
      target_request_i = 1'b1;
      target_addr_i    = addr;
      invalidate_i     = inv;
      sb.push_back(exp);
      saw_cyc = 1'b0; lat = 0; adr_seen = 32'd0; cyc_cnt = 0; got = 1'b0;
      for (int c = 1; c <= 1500 && !got; c++) begin
         @(posedge clk_i); #1;
         invalidate_i = 1'b0;
         wb.ack = 1'b0;
         wb.err = 1'b0;
         if (wb.cyc) begin
            if (!saw_cyc) adr_seen = wb.adr;
            saw_cyc = 1'b1;
            cyc_cnt++;
            if (mode == 0 && cyc_cnt == dly) begin
               wb.ack   = 1'b1;
               wb.dat_r = cur_line;
            end
            if (mode == 1 && cyc_cnt == dly) wb.err = 1'b1;
         end
         if (target_ack_o) begin
            got = 1'b1;
            lat = c;
            target_request_i = 1'b0;
            d = (sb.size() > 0) ? sb.pop_front() : 32'hXXXX_XXXX;
            check("rdata", target_data_o, d);
         end
      end
      if (!got) begin
         check("ack_wait", 32'(got), 32'd1);
         target_request_i = 1'b0;
         sb.delete();
      end
      @(posedge clk_i); #1;
      check("single_ack", 32'(target_ack_o), 32'd0);
   endtask

   initial begin
      logic        sc;
      int          lat;
      int          cc;
      logic [31:0] adr;
      logic        seen;

      wb.ack = 1'b0; wb.err = 1'b0; wb.dat_r = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ack",  32'(target_ack_o), 32'd0);
      check("rst_data", target_data_o,     32'd0);
      check("rst_busy", 32'(wbm_busy_o),   32'd0);
      check("rst_err",  32'(err_o),        32'd0);
      check("rst_cyc",  32'(wb.cyc),       32'd0);
      check("rst_stb",  32'(wb.stb),       32'd0);
      check("rst_adr",  wb.adr,            32'd0);
      check("rst_sel",  wb.sel,            32'd0);
      @(negedge clk_i); rst_ni = 1'b1;

      // Cold miss, word1 = DEADBEEF, ack on third bus cycle
      cur_line = mk_line(32'h1111_0000);
      cur_line[63:32] = 32'hDEAD_BEEF;
      fork
         begin
            // cycle-accurate sel/we/stb sanity while the miss is on the bus
            @(posedge wb.cyc); #1;
            check("miss_sel", wb.sel, 32'hFFFF_FFFF);
            check("miss_we",  32'(wb.we), 32'd0);
            check("miss_stb", 32'(wb.stb), 32'd1);
            check("miss_busy", 32'(wbm_busy_o), 32'd1);
         end
         do_req(32'h1000_0024, 32'hDEAD_BEEF, 0, 3, 1'b0, sc, lat, adr, cc);
      join
      check("miss_cyc", 32'(sc),  32'd1);
      check("miss_adr", adr,      32'h1000_0020);
      check("miss_lat", 32'(lat), 32'd5);

      // Hit in the same line: no bus, one-clock latency, word6
      do_req(32'h1000_0038, 32'h1111_0006, 0, 1, 1'b0, sc, lat, adr, cc);
      check("hit_nocyc", 32'(sc),  32'd0);
      check("hit_lat",   32'(lat), 32'd1);
      do_req(32'h1000_0020, 32'h1111_0000, 0, 1, 1'b0, sc, lat, adr, cc);
      check("hit2_nocyc", 32'(sc), 32'd0);

      // Invalidate pulse then the same address must refetch
      @(negedge clk_i); invalidate_i = 1'b1;
      @(negedge clk_i); invalidate_i = 1'b0;
      cur_line = mk_line(32'h2222_0000);
      do_req(32'h1000_0038, 32'h2222_0006, 0, 2, 1'b0, sc, lat, adr, cc);
      check("inv_cyc", 32'(sc), 32'd1);
      check("inv_lat", 32'(lat), 32'd4);

      // Invalidate coincident with what would be a hit: treated as a miss
      cur_line = mk_line(32'h3333_0000);
      do_req(32'h1000_002C, 32'h3333_0003, 0, 1, 1'b1, sc, lat, adr, cc);
      check("inv_hit_cyc", 32'(sc), 32'd1);

      // Bus error on fill
      do_req(32'h2000_0004, 32'h0000_0000, 1, 2, 1'b0, sc, lat, adr, cc);
      check("err_cyc", 32'(sc),   32'd1);
      check("err_flag", 32'(err_o), 32'd1);
      cur_line = mk_line(32'h4444_0000);
      do_req(32'h2000_0008, 32'h4444_0002, 0, 1, 1'b0, sc, lat, adr, cc);
      check("err_refetch", 32'(sc), 32'd1);
      check("err_sticky", 32'(err_o), 32'd1);
      @(negedge clk_i); err_clr_i = 1'b1;
      @(negedge clk_i); err_clr_i = 1'b0;
      check("err_clr", 32'(err_o), 32'd0);

      // Timeout: no termination at all
      do_req(32'h3000_0010, 32'h0000_0000, 2, 0, 1'b0, sc, lat, adr, cc);
      check("to_cycles", 32'(cc),  32'(TIMEOUT + 1));
      check("to_lat",    32'(lat), 32'(TIMEOUT + 3));
      check("to_cyc_off", 32'(wb.cyc), 32'd0);
      check("to_err",    32'(err_o), 32'd1);
      check("to_idle",   32'(wbm_busy_o), 32'd0);

      // Fill a line, then reset in the middle of another miss
      cur_line = mk_line(32'h5555_0000);
      do_req(32'h4000_0004, 32'h5555_0001, 0, 1, 1'b0, sc, lat, adr, cc);
      do_req(32'h4000_0008, 32'h5555_0002, 0, 1, 1'b0, sc, lat, adr, cc);
      check("pre_rst_hit", 32'(sc), 32'd0);
      @(negedge clk_i);
      target_request_i = 1'b1;
      target_addr_i    = 32'h5000_0000;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk_i); #1;
         seen = wb.cyc;
      end
      check("rst_mid_seen", 32'(seen), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      check("rst_mid_cyc",  32'(wb.cyc),     32'd0);
      check("rst_mid_stb",  32'(wb.stb),     32'd0);
      check("rst_mid_busy", 32'(wbm_busy_o), 32'd0);
      check("rst_mid_err",  32'(err_o),      32'd0);
      target_request_i = 1'b0;
      @(negedge clk_i); rst_ni = 1'b1;
      cur_line = mk_line(32'h6666_0000);
      do_req(32'h4000_0004, 32'h6666_0001, 0, 1, 1'b0, sc, lat, adr, cc);
      check("post_rst_miss", 32'(sc), 32'd1);
      check("post_rst_adr",  adr,     32'h4000_0000);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
